branch_predict_fetch_pc: RTL and testbench

//  Fetch-address generator sitting directly upstream of the branch cache.

---
 rtl/branch_predict_fetch_pc_if.sv | 44 ++++
 rtl/branch_predict_fetch_pc.sv | 173 +++++++++++++++++
 tb/tb_branch_predict_fetch_pc.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_predict_fetch_pc_if.sv
// rtl/branch_predict_fetch_pc_if.sv - fetch PC generator bus: flush/redirect, branch cache search, fetch request, prediction queue
interface branch_predict_fetch_pc_if;
   logic        iFLUSH;
   logic        iREDIRECT_VALID;
   logic [31:0] iREDIRECT_ADDR;
   logic        oSEARCH_STB;
   logic [31:0] oSEARCH_INST_ADDR;
   logic        iSEARCH_VALID;
   logic        iSEARCH_HIT;
   logic        iSEARCH_PREDICT_BRANCH;
   logic [31:0] iSEARCH_ADDR;
   logic        oFETCH_REQ;
   logic [31:0] oFETCH_ADDR;
   logic        oFETCH_PREDICT_TAKEN;
   logic        iFETCH_BUSY;
   logic        oPRED_VALID;
   logic [31:0] oPRED_INST_ADDR;
   logic        oPRED_TAKEN;
   logic [31:0] oPRED_TARGET;
   logic        iPRED_POP;
   logic        oPRED_FULL;

   modport master (
      input  iFLUSH, iREDIRECT_VALID, iREDIRECT_ADDR,
      output oSEARCH_STB, oSEARCH_INST_ADDR,
      input  iSEARCH_VALID, iSEARCH_HIT, iSEARCH_PREDICT_BRANCH, iSEARCH_ADDR,
      output oFETCH_REQ, oFETCH_ADDR, oFETCH_PREDICT_TAKEN,
      input  iFETCH_BUSY,
      output oPRED_VALID, oPRED_INST_ADDR, oPRED_TAKEN, oPRED_TARGET,
      input  iPRED_POP,
      output oPRED_FULL
   );

   modport slave (
      output iFLUSH, iREDIRECT_VALID, iREDIRECT_ADDR,
      input  oSEARCH_STB, oSEARCH_INST_ADDR,
      output iSEARCH_VALID, iSEARCH_HIT, iSEARCH_PREDICT_BRANCH, iSEARCH_ADDR,
      input  oFETCH_REQ, oFETCH_ADDR, oFETCH_PREDICT_TAKEN,
      output iFETCH_BUSY,
      input  oPRED_VALID, oPRED_INST_ADDR, oPRED_TAKEN, oPRED_TARGET,
      output iPRED_POP,
      input  oPRED_FULL
   );
endinterface

// File: rtl/branch_predict_fetch_pc.sv
// rtl/branch_predict_fetch_pc.sv - fetch PC generator with branch cache search and in-order prediction record queue
// Define BRANCH_PREDICT_FETCH_BYPASS_EN to disable prediction: no search strobes, PC always advances by 4.
module branch_predict_fetch_pc #(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter int unsigned PRED_DEPTH_N = 2
)(
   input  logic                       iCLOCK,
   input  logic                       inRESET,
   branch_predict_fetch_pc_if.master  bus
);
   localparam int unsigned             DEPTH     = 1 << PRED_DEPTH_N;
   localparam logic [PRED_DEPTH_N:0]   CNT_DEPTH = (PRED_DEPTH_N + 1)'(DEPTH);
   localparam logic [PRED_DEPTH_N:0]   CNT_ONE   = (PRED_DEPTH_N + 1)'(1);
   localparam logic [31:0]             PC_INIT   = {RESET_PC[31:2], 2'b00};

   typedef enum logic [1:0] {
      ST_INIT   = 2'd0,
      ST_RUN    = 2'd1,
      ST_BUBBLE = 2'd2
   } state_t;

   typedef struct packed {
      logic [31:0] addr;
      logic        taken;
      logic [31:0] target;
   } pred_rec_t;

   state_t                  state_q;
   state_t                  state_d;

   logic [31:0]             b_pc;
   logic                    fetch_req_q;
   logic [31:0]             fetch_addr_q;
   logic                    fetch_taken_q;

   pred_rec_t               rec_mem [DEPTH];
   pred_rec_t               head_rec;
   logic [PRED_DEPTH_N:0]   count_q;
   logic [PRED_DEPTH_N-1:0] head_q;
   logic [PRED_DEPTH_N-1:0] tail_q;

   logic                    disrupt;
   logic                    issue;
   logic                    taken;
   logic                    full;
   logic                    empty;
   logic                    do_pop;
   logic [31:0]             next_pc;
   logic [31:0]             redirect_pc;

   assign full        = (count_q == CNT_DEPTH);
   assign empty       = (count_q == '0);
   assign redirect_pc = {bus.iREDIRECT_ADDR[31:2], 2'b00};

   // Flush/redirect only take effect once out of INIT; the registered fetch
   // request gates issue so a stalled request is never overwritten.
   always_comb begin
      state_d = state_q;
      disrupt = 1'b0;
      issue   = 1'b0;
      unique case (state_q)
         ST_INIT: begin
            state_d = ST_RUN;
         end
         ST_RUN: begin
            disrupt = bus.iFLUSH | bus.iREDIRECT_VALID;
            issue   = !disrupt && !full && (!fetch_req_q || !bus.iFETCH_BUSY);
            if (disrupt) begin
               state_d = ST_BUBBLE;
            end
         end
         ST_BUBBLE: begin
            disrupt = bus.iFLUSH | bus.iREDIRECT_VALID;
            state_d = disrupt ? ST_BUBBLE : ST_RUN;
         end
         default: begin
            state_d = ST_INIT;
         end
      endcase
   end

   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         state_q <= ST_INIT;
      end else begin
         state_q <= state_d;
      end
   end

`ifdef BRANCH_PREDICT_FETCH_BYPASS_EN
   logic unused_search;
   assign unused_search   = ^{bus.iSEARCH_VALID, bus.iSEARCH_HIT, bus.iSEARCH_PREDICT_BRANCH,
                              bus.iSEARCH_ADDR, bus.iREDIRECT_ADDR[1:0]};
   assign taken           = 1'b0;
   assign bus.oSEARCH_STB = 1'b0;
   assign next_pc         = b_pc + 32'd4;
`else
   logic unused_low_bits;
   assign unused_low_bits = ^{bus.iSEARCH_ADDR[1:0], bus.iREDIRECT_ADDR[1:0]};
   assign taken           = bus.iSEARCH_VALID & bus.iSEARCH_HIT & bus.iSEARCH_PREDICT_BRANCH;
   assign bus.oSEARCH_STB = issue;
   assign next_pc         = taken ? {bus.iSEARCH_ADDR[31:2], 2'b00} : b_pc + 32'd4;
`endif

   assign bus.oSEARCH_INST_ADDR = b_pc;

   // Flush keeps the PC; redirect loads the resolved target. Both drop any
   // pending fetch request even if the fetch stage is busy.
   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         b_pc          <= PC_INIT;
         fetch_req_q   <= 1'b0;
         fetch_addr_q  <= '0;
         fetch_taken_q <= 1'b0;
      end else if (disrupt) begin
         fetch_req_q <= 1'b0;
         if (!bus.iFLUSH) begin
            b_pc <= redirect_pc;
         end
      end else if (issue) begin
         b_pc          <= next_pc;
         fetch_req_q   <= 1'b1;
         fetch_addr_q  <= b_pc;
         fetch_taken_q <= taken;
      end else if (fetch_req_q && !bus.iFETCH_BUSY) begin
         fetch_req_q <= 1'b0;
      end
   end

   assign bus.oFETCH_REQ           = fetch_req_q;
   assign bus.oFETCH_ADDR          = fetch_addr_q;
   assign bus.oFETCH_PREDICT_TAKEN = fetch_taken_q;

   assign do_pop = bus.iPRED_POP && !empty && !disrupt;

   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         count_q <= '0;
         head_q  <= '0;
         tail_q  <= '0;
      end else if (disrupt) begin
         count_q <= '0;
         head_q  <= '0;
         tail_q  <= '0;
      end else begin
         if (issue) begin
            tail_q <= tail_q + 1'b1;
         end
         if (do_pop) begin
            head_q <= head_q + 1'b1;
         end
         unique case ({issue, do_pop})
            2'b10:   count_q <= count_q + CNT_ONE;
            2'b01:   count_q <= count_q - CNT_ONE;
            default: count_q <= count_q;
         endcase
      end
   end

   // Issue is blocked while full, so a push never lands on a live entry.
   always_ff @(posedge iCLOCK) begin
      if (issue) begin
         rec_mem[tail_q] <= '{addr: b_pc, taken: taken, target: next_pc};
      end
   end

   assign head_rec            = rec_mem[head_q];
   assign bus.oPRED_VALID     = !empty;
   assign bus.oPRED_INST_ADDR = empty ? '0 : head_rec.addr;
   assign bus.oPRED_TAKEN     = empty ? 1'b0 : head_rec.taken;
   assign bus.oPRED_TARGET    = empty ? '0 : head_rec.target;
   assign bus.oPRED_FULL      = full;
endmodule

// File: tb/tb_branch_predict_fetch_pc.sv
// tb/tb_branch_predict_fetch_pc.sv - directed scenarios plus randomized run against a queue-based reference model
module tb_branch_predict_fetch_pc;
   logic iCLOCK;
   logic inRESET;
   int   checks;
   int   errors;

   branch_predict_fetch_pc_if bus();

   branch_predict_fetch_pc #(
      .RESET_PC     (32'h0000_0100),
      .PRED_DEPTH_N (2)
   ) dut (
      .iCLOCK  (iCLOCK),
      .inRESET (inRESET),
      .bus     (bus)
   );

   initial iCLOCK = 1'b0;
   always #5 iCLOCK = ~iCLOCK;

   typedef struct {
      logic [31:0] addr;
      logic        taken;
      logic [31:0] target;
   } rec_t;

   rec_t        m_q[$];
   logic [31:0] m_pc;
   logic        m_started;
   int          m_bubble;
   logic        m_req;
   logic [31:0] m_faddr;
   logic        m_ftaken;

   task automatic model_reset();
      m_q.delete();
      m_pc      = 32'h100;
      m_started = 1'b0;
      m_bubble  = 0;
      m_req     = 1'b0;
      m_faddr   = '0;
      m_ftaken  = 1'b0;
   endtask

   function automatic logic m_issue();
      return m_started && (m_bubble == 0) && (m_q.size() < 4) &&
             (!m_req || !bus.iFETCH_BUSY) && !bus.iFLUSH && !bus.iREDIRECT_VALID;
   endfunction

   task automatic model_update();
      logic        iss;
      logic        tk;
      logic        disrupted;
      logic [31:0] nxt;
      rec_t        r;
      iss       = m_issue();
      tk        = bus.iSEARCH_VALID & bus.iSEARCH_HIT & bus.iSEARCH_PREDICT_BRANCH;
      nxt       = tk ? (bus.iSEARCH_ADDR & ~32'd3) : m_pc + 32'd4;
      disrupted = m_started && (bus.iFLUSH || bus.iREDIRECT_VALID);
      if (disrupted) begin
         m_q.delete();
         m_req    = 1'b0;
         m_bubble = 1;
         if (!bus.iFLUSH) m_pc = bus.iREDIRECT_ADDR & ~32'd3;
      end else begin
         if (m_started) m_bubble = 0;
         m_started = 1'b1;
         if (bus.iPRED_POP && m_q.size() > 0) void'(m_q.pop_front());
         if (iss) begin
            r.addr   = m_pc;
            r.taken  = tk;
            r.target = nxt;
            m_q.push_back(r);
            m_faddr  = m_pc;
            m_ftaken = tk;
            m_req    = 1'b1;
            m_pc     = nxt;
         end else if (m_req && !bus.iFETCH_BUSY) begin
            m_req = 1'b0;
         end
      end
   endtask

   task automatic step();
      @(posedge iCLOCK);
      if (!inRESET) model_reset();
      else model_update();
      #1;
   endtask

   task automatic clr_inputs();
      bus.iFLUSH                 = 1'b0;
      bus.iREDIRECT_VALID        = 1'b0;
      bus.iREDIRECT_ADDR         = '0;
      bus.iSEARCH_VALID          = 1'b0;
      bus.iSEARCH_HIT            = 1'b0;
      bus.iSEARCH_PREDICT_BRANCH = 1'b0;
      bus.iSEARCH_ADDR           = '0;
      bus.iFETCH_BUSY            = 1'b0;
      bus.iPRED_POP              = 1'b0;
   endtask

   task automatic test_reset();
      inRESET = 1'b0;
      clr_inputs();
      step();
      step();
      checks++; if (bus.oFETCH_REQ !== 1'b0) begin errors++; $display("FAIL reset_req got %0h exp 0", bus.oFETCH_REQ); end
      checks++; if (bus.oFETCH_ADDR !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", bus.oFETCH_ADDR); end
      checks++; if (bus.oSEARCH_STB !== 1'b0) begin errors++; $display("FAIL reset_stb got %0h exp 0", bus.oSEARCH_STB); end
      checks++; if (bus.oPRED_VALID !== 1'b0) begin errors++; $display("FAIL reset_pred_valid got %0h exp 0", bus.oPRED_VALID); end
      checks++; if (bus.oPRED_FULL !== 1'b0) begin errors++; $display("FAIL reset_full got %0h exp 0", bus.oPRED_FULL); end
      checks++; if (bus.oPRED_TARGET !== 32'h0) begin errors++; $display("FAIL reset_pred_target got %h exp 0", bus.oPRED_TARGET); end
      inRESET = 1'b1;
   endtask

   task automatic test_sequential();
      #1;
      checks++; if (bus.oSEARCH_STB !== 1'b0) begin errors++; $display("FAIL seq_init_stb got %0h exp 0", bus.oSEARCH_STB); end
      step();
      checks++; if (bus.oFETCH_REQ !== 1'b0) begin errors++; $display("FAIL seq_latency_req got %0h exp 0", bus.oFETCH_REQ); end
      checks++; if (bus.oSEARCH_STB !== 1'b1 || bus.oSEARCH_INST_ADDR !== 32'h100) begin errors++; $display("FAIL seq_search0 got %0h/%h exp 1/00000100", bus.oSEARCH_STB, bus.oSEARCH_INST_ADDR); end
      step();
      checks++; if (bus.oFETCH_REQ !== 1'b1 || bus.oFETCH_ADDR !== 32'h100) begin errors++; $display("FAIL seq_fetch0 got %0h/%h exp 1/00000100", bus.oFETCH_REQ, bus.oFETCH_ADDR); end
      step();
      checks++; if (bus.oFETCH_ADDR !== 32'h104 || bus.oFETCH_PREDICT_TAKEN !== 1'b0) begin errors++; $display("FAIL seq_fetch1 got %h/%0h exp 00000104/0", bus.oFETCH_ADDR, bus.oFETCH_PREDICT_TAKEN); end
   endtask

   task automatic test_taken();
      bus.iSEARCH_VALID          = 1'b1;
      bus.iSEARCH_HIT            = 1'b1;
      bus.iSEARCH_PREDICT_BRANCH = 1'b1;
      bus.iSEARCH_ADDR           = 32'h203;
      #1;
      checks++; if (bus.oSEARCH_STB !== 1'b1 || bus.oSEARCH_INST_ADDR !== 32'h108) begin errors++; $display("FAIL taken_search got %0h/%h exp 1/00000108", bus.oSEARCH_STB, bus.oSEARCH_INST_ADDR); end
      step();
      checks++; if (bus.oFETCH_ADDR !== 32'h108 || bus.oFETCH_PREDICT_TAKEN !== 1'b1) begin errors++; $display("FAIL taken_fetch got %h/%0h exp 00000108/1", bus.oFETCH_ADDR, bus.oFETCH_PREDICT_TAKEN); end
      checks++; if (bus.oSEARCH_INST_ADDR !== 32'h200) begin errors++; $display("FAIL taken_next_pc got %h exp 00000200", bus.oSEARCH_INST_ADDR); end
      clr_inputs();
      bus.iPRED_POP = 1'b1;
      step();
      checks++; if (bus.oFETCH_ADDR !== 32'h200 || bus.oPRED_INST_ADDR !== 32'h104) begin errors++; $display("FAIL taken_after got %h/%h exp 00000200/00000104", bus.oFETCH_ADDR, bus.oPRED_INST_ADDR); end
      step();
      bus.iPRED_POP = 1'b0;
      checks++; if (bus.oPRED_INST_ADDR !== 32'h108 || bus.oPRED_TAKEN !== 1'b1 || bus.oPRED_TARGET !== 32'h200) begin errors++; $display("FAIL taken_record got %h/%0h/%h exp 00000108/1/00000200", bus.oPRED_INST_ADDR, bus.oPRED_TAKEN, bus.oPRED_TARGET); end
   endtask

   task automatic test_busy();
      bus.iFETCH_BUSY = 1'b1;
      #1;
      checks++; if (bus.oSEARCH_STB !== 1'b0) begin errors++; $display("FAIL busy_stb0 got %0h exp 0", bus.oSEARCH_STB); end
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (bus.oFETCH_REQ !== 1'b1 || bus.oFETCH_ADDR !== 32'h204) begin errors++; $display("FAIL busy_hold%0d got %0h/%h exp 1/00000204", i, bus.oFETCH_REQ, bus.oFETCH_ADDR); end
         checks++; if (bus.oSEARCH_STB !== 1'b0 || bus.oSEARCH_INST_ADDR !== 32'h208) begin errors++; $display("FAIL busy_pc%0d got %0h/%h exp 0/00000208", i, bus.oSEARCH_STB, bus.oSEARCH_INST_ADDR); end
      end
      bus.iFETCH_BUSY = 1'b0;
      step();
      checks++; if (bus.oFETCH_ADDR !== 32'h208 || bus.oPRED_FULL !== 1'b1) begin errors++; $display("FAIL busy_release got %h/%0h exp 00000208/1", bus.oFETCH_ADDR, bus.oPRED_FULL); end
   endtask

   task automatic test_full();
      checks++; if (bus.oSEARCH_STB !== 1'b0) begin errors++; $display("FAIL full_stb got %0h exp 0", bus.oSEARCH_STB); end
      step();
      checks++; if (bus.oFETCH_REQ !== 1'b0 || bus.oPRED_FULL !== 1'b1 || bus.oSEARCH_INST_ADDR !== 32'h20C) begin errors++; $display("FAIL full_stall got %0h/%0h/%h exp 0/1/0000020c", bus.oFETCH_REQ, bus.oPRED_FULL, bus.oSEARCH_INST_ADDR); end
      bus.iPRED_POP = 1'b1;
      #1;
      checks++; if (bus.oSEARCH_STB !== 1'b0) begin errors++; $display("FAIL full_pop_stb got %0h exp 0", bus.oSEARCH_STB); end
      step();
      bus.iPRED_POP = 1'b0;
      #1;
      checks++; if (bus.oPRED_FULL !== 1'b0 || bus.oFETCH_REQ !== 1'b0 || bus.oPRED_INST_ADDR !== 32'h200) begin errors++; $display("FAIL full_after_pop got %0h/%0h/%h exp 0/0/00000200", bus.oPRED_FULL, bus.oFETCH_REQ, bus.oPRED_INST_ADDR); end
      checks++; if (bus.oSEARCH_STB !== 1'b1) begin errors++; $display("FAIL full_resume_stb got %0h exp 1", bus.oSEARCH_STB); end
      step();
      checks++; if (bus.oFETCH_ADDR !== 32'h20C || bus.oPRED_FULL !== 1'b1) begin errors++; $display("FAIL full_refill got %h/%0h exp 0000020c/1", bus.oFETCH_ADDR, bus.oPRED_FULL); end
   endtask

   task automatic test_redirect();
      bus.iPRED_POP   = 1'b1;
      bus.iFETCH_BUSY = 1'b1;
      step();
      checks++; if (bus.oPRED_FULL !== 1'b0 || bus.oFETCH_REQ !== 1'b1 || bus.oPRED_INST_ADDR !== 32'h204) begin errors++; $display("FAIL redir_setup got %0h/%0h/%h exp 0/1/00000204", bus.oPRED_FULL, bus.oFETCH_REQ, bus.oPRED_INST_ADDR); end
      bus.iREDIRECT_VALID = 1'b1;
      bus.iREDIRECT_ADDR  = 32'h403;
      #1;
      checks++; if (bus.oSEARCH_STB !== 1'b0) begin errors++; $display("FAIL redir_stb got %0h exp 0", bus.oSEARCH_STB); end
      step();
      checks++; if (bus.oPRED_VALID !== 1'b0 || bus.oFETCH_REQ !== 1'b0 || bus.oSEARCH_INST_ADDR !== 32'h400) begin errors++; $display("FAIL redir_clear got %0h/%0h/%h exp 0/0/00000400", bus.oPRED_VALID, bus.oFETCH_REQ, bus.oSEARCH_INST_ADDR); end
      clr_inputs();
      #1;
      checks++; if (bus.oSEARCH_STB !== 1'b0) begin errors++; $display("FAIL redir_bubble_stb got %0h exp 0", bus.oSEARCH_STB); end
      step();
      checks++; if (bus.oSEARCH_STB !== 1'b1 || bus.oSEARCH_INST_ADDR !== 32'h400) begin errors++; $display("FAIL redir_issue got %0h/%h exp 1/00000400", bus.oSEARCH_STB, bus.oSEARCH_INST_ADDR); end
      step();
      checks++; if (bus.oFETCH_REQ !== 1'b1 || bus.oFETCH_ADDR !== 32'h400 || bus.oPRED_INST_ADDR !== 32'h400) begin errors++; $display("FAIL redir_fetch got %0h/%h/%h exp 1/00000400/00000400", bus.oFETCH_REQ, bus.oFETCH_ADDR, bus.oPRED_INST_ADDR); end
   endtask

   task automatic test_wrap_flush();
      bus.iREDIRECT_VALID = 1'b1;
      bus.iREDIRECT_ADDR  = 32'hFFFF_FFFC;
      step();
      clr_inputs();
      step();
      checks++; if (bus.oSEARCH_STB !== 1'b1 || bus.oSEARCH_INST_ADDR !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_search got %0h/%h exp 1/fffffffc", bus.oSEARCH_STB, bus.oSEARCH_INST_ADDR); end
      step();
      checks++; if (bus.oFETCH_ADDR !== 32'hFFFF_FFFC || bus.oSEARCH_INST_ADDR !== 32'h0) begin errors++; $display("FAIL wrap_next got %h/%h exp fffffffc/00000000", bus.oFETCH_ADDR, bus.oSEARCH_INST_ADDR); end
      step();
      checks++; if (bus.oFETCH_ADDR !== 32'h0 || bus.oPRED_TARGET !== 32'h0 || bus.oPRED_INST_ADDR !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_fetch got %h/%h/%h exp 00000000/00000000/fffffffc", bus.oFETCH_ADDR, bus.oPRED_TARGET, bus.oPRED_INST_ADDR); end
      bus.iFLUSH          = 1'b1;
      bus.iREDIRECT_VALID = 1'b1;
      bus.iREDIRECT_ADDR  = 32'h800;
      step();
      checks++; if (bus.oSEARCH_INST_ADDR !== 32'h4 || bus.oPRED_VALID !== 1'b0 || bus.oFETCH_REQ !== 1'b0) begin errors++; $display("FAIL flush_prio got %h/%0h/%0h exp 00000004/0/0", bus.oSEARCH_INST_ADDR, bus.oPRED_VALID, bus.oFETCH_REQ); end
      clr_inputs();
      #1;
      checks++; if (bus.oSEARCH_STB !== 1'b0) begin errors++; $display("FAIL flush_bubble_stb got %0h exp 0", bus.oSEARCH_STB); end
      step();
      checks++; if (bus.oSEARCH_STB !== 1'b1 || bus.oSEARCH_INST_ADDR !== 32'h4) begin errors++; $display("FAIL flush_resume got %0h/%h exp 1/00000004", bus.oSEARCH_STB, bus.oSEARCH_INST_ADDR); end
   endtask

   task automatic test_random();
      inRESET = 1'b0;
      clr_inputs();
      model_reset();
      step();
      inRESET = 1'b1;
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 79) == 0) begin
            inRESET = 1'b0;
            clr_inputs();
            model_reset();
            #1;
            checks++; if (bus.oFETCH_REQ !== 1'b0 || bus.oPRED_VALID !== 1'b0 || bus.oPRED_FULL !== 1'b0 || bus.oSEARCH_STB !== 1'b0) begin errors++; $display("FAIL rand_async_reset cyc %0d got %0h%0h%0h%0h exp 0000", n, bus.oFETCH_REQ, bus.oPRED_VALID, bus.oPRED_FULL, bus.oSEARCH_STB); end
            step();
            inRESET = 1'b1;
         end
         bus.iFLUSH                 = ($urandom_range(0, 19) == 0);
         bus.iREDIRECT_VALID        = ($urandom_range(0, 11) == 0);
         bus.iREDIRECT_ADDR         = $urandom();
         bus.iSEARCH_VALID          = ($urandom_range(0, 9) < 7);
         bus.iSEARCH_HIT            = $urandom_range(0, 1);
         bus.iSEARCH_PREDICT_BRANCH = $urandom_range(0, 1);
         bus.iSEARCH_ADDR           = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : $urandom();
         bus.iFETCH_BUSY            = ($urandom_range(0, 9) < 3);
         bus.iPRED_POP              = $urandom_range(0, 1);
         #1;
         checks++; if (bus.oSEARCH_STB !== m_issue() || bus.oSEARCH_INST_ADDR !== m_pc) begin errors++; $display("FAIL rand_search cyc %0d got %0h/%h exp %0h/%h", n, bus.oSEARCH_STB, bus.oSEARCH_INST_ADDR, m_issue(), m_pc); end
         step();
         checks++; if (bus.oFETCH_REQ !== m_req) begin errors++; $display("FAIL rand_req cyc %0d got %0h exp %0h", n, bus.oFETCH_REQ, m_req); end
         if (m_req) begin
            checks++; if (bus.oFETCH_ADDR !== m_faddr || bus.oFETCH_PREDICT_TAKEN !== m_ftaken) begin errors++; $display("FAIL rand_fetch cyc %0d got %h/%0h exp %h/%0h", n, bus.oFETCH_ADDR, bus.oFETCH_PREDICT_TAKEN, m_faddr, m_ftaken); end
         end
         checks++; if (bus.oPRED_VALID !== (m_q.size() > 0) || bus.oPRED_FULL !== (m_q.size() == 4)) begin errors++; $display("FAIL rand_count cyc %0d got valid %0h full %0h exp size %0d", n, bus.oPRED_VALID, bus.oPRED_FULL, m_q.size()); end
         if (m_q.size() > 0) begin
            checks++; if (bus.oPRED_INST_ADDR !== m_q[0].addr || bus.oPRED_TAKEN !== m_q[0].taken || bus.oPRED_TARGET !== m_q[0].target) begin errors++; $display("FAIL rand_head cyc %0d got %h/%0h/%h exp %h/%0h/%h", n, bus.oPRED_INST_ADDR, bus.oPRED_TAKEN, bus.oPRED_TARGET, m_q[0].addr, m_q[0].taken, m_q[0].target); end
         end
      end
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      inRESET = 1'b0;
      clr_inputs();
      model_reset();
      test_reset();
      test_sequential();
      test_taken();
      test_busy();
      test_full();
      test_redirect();
      test_wrap_flush();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
